// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: byte width, FSM encoding
// and a helper that sizes saturating counters.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Width of a counter that must hold values 0..maxv; never narrower than
  // one bit, so a disabled feature (maxv = 0) still elaborates cleanly.
  function automatic int cnt_w(input int maxv);
    return (maxv > 0) ? $clog2(maxv + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: starting just above the last winner and wrapping,
// returns the one-hot of the first asserted request (all zero if none).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o
);

  logic          found;
  logic [IW-1:0] idx;

  // Scan offsets 1..NREQ from last so that last itself is checked last.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IW'((int'(last_i) + off) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto a single 8N1 transmitter. A winner
// is chosen round-robin in IDLE, its byte is registered and a one-cycle
// start pulse issued; the FSM then waits for the frame-done pulse (with an
// optional timeout) and inserts GAP idle cycles before arbitrating again.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int GAP     = 16,
  parameter int TIMEOUT = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*BYTE_W-1:0]   req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic [BYTE_W-1:0]        tx_byte_o,
  output logic                     tx_start_o,
  input  logic                     tx_done_i,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o,
  output logic                     err_timeout_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = cnt_w(GAP);
  localparam int TW = cnt_w(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     last_q,  last_d;
  logic [BYTE_W-1:0] byte_q,  byte_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              start_q, start_d;
  logic              err_q,   err_d;
  logic [GW-1:0]     gcnt_q,  gcnt_d;
  logic [TW-1:0]     tcnt_q,  tcnt_d;

  logic [NREQ-1:0]   winner;
  logic [BYTE_W-1:0] win_byte;
  logic [IW-1:0]     win_idx;
  logic              handshake;
  logic              expire;
  logic              leave_wait;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (winner)
  );

  // Ready is offered only while idle; the winner is always a valid requester,
  // so any valid request in IDLE completes a transfer this cycle.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) ? winner : '0;
    handshake   = (state_q == ST_IDLE) && (|req_valid_i);
  end

  // Select the winner's byte and encode its index for the round-robin pointer.
  always_comb begin
    win_byte = '0;
    win_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner[k]) begin
        win_byte = req_data_i[k*BYTE_W +: BYTE_W];
        win_idx  = IW'(k);
      end
    end
  end

  // Next-state logic; tx_done_i is only looked at in WAIT, where it beats
  // a timeout expiring in the same cycle.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    byte_d     = byte_q;
    grant_d    = grant_q;
    start_d    = 1'b0;
    err_d      = err_q;
    gcnt_d     = gcnt_q;
    tcnt_d     = tcnt_q;
    expire     = (TIMEOUT > 0) && (int'(tcnt_q) == TIMEOUT - 1);
    leave_wait = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          byte_d  = win_byte;
          grant_d = winner;
          last_d  = win_idx;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_i) begin
          leave_wait = 1'b1;
        end else if (expire) begin
          err_d      = 1'b1;
          leave_wait = 1'b1;
        end else if (TIMEOUT > 0) begin
          tcnt_d = tcnt_q + TW'(1);
        end
        if (leave_wait) begin
          tcnt_d = '0;
          gcnt_d = '0;
          if (GAP == 0) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (int'(gcnt_q) == GAP - 1) begin
          gcnt_d  = '0;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset leaves last at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      byte_q  <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      grant_q <= grant_d;
      start_q <= start_d;
      err_q   <= err_d;
      gcnt_q  <= gcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Outputs are straight from registers or a state decode.
  always_comb begin
    tx_byte_o     = byte_q;
    tx_start_o    = start_q;
    grant_o       = grant_q;
    busy_o        = (state_q != ST_IDLE);
    err_timeout_o = err_q;
  end

endmodule
